// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter.
//   N_REQ    : number of CDB requesters (add1..add3, mul1..mul2, load/store)
//   TAG_W    : ROB index width (8-entry reorder buffer)
//   DATA_W   : result width
//   MAX_WAIT : wait cycles at which a requester is flagged as starved
//   next_ptr : round-robin pointer advance with wrap from N_REQ-1 to 0
package cdb_pkg;

    localparam int N_REQ    = 6;
    localparam int TAG_W    = 3;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 15;
    localparam int WAIT_W   = 4;
    localparam int IDX_W    = $clog2(N_REQ);

    localparam int REQ_ADD1 = 0;
    localparam int REQ_ADD2 = 1;
    localparam int REQ_ADD3 = 2;
    localparam int REQ_MUL1 = 3;
    localparam int REQ_MUL2 = 4;
    localparam int REQ_LS   = 5;

    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
        return (w == IDX_W'(N_REQ - 1)) ? '0 : w + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// CDB request/broadcast bundle.
//   req/req_tag/req_data : per-requester completed result (tag/data sliced by index)
//   cdb_stall, flush     : ROB back-pressure and pipeline flush
//   grant                : one-hot, combinational
//   cdb_valid/tag/data   : registered broadcast
//   starve               : registered per-requester starvation flags
// master = the arbiter, slave = the requesters / consumers.
interface cdb_arbiter_if;
    import cdb_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    cdb_stall;
    logic                    flush;
    logic [N_REQ-1:0]        grant;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [N_REQ-1:0]        starve;

    modport master (
        input  req, req_tag, req_data, cdb_stall, flush,
        output grant, cdb_valid, cdb_tag, cdb_data, starve
    );

    modport slave (
        output req, req_tag, req_data, cdb_stall, flush,
        input  grant, cdb_valid, cdb_tag, cdb_data, starve
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index scanned first (must be < N)
//   grant_o : one-hot of the first set request at ptr_i, ptr_i+1, ... mod N
//   idx_o   : encoded index of grant_o
//   valid_o : any request present
module rr_arbiter #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        int j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completed result per cycle (starved
// requesters first, lowest index; otherwise round-robin from rr_ptr) and
// broadcasts its ROB tag and data one cycle later.
//   clk, rst : clock and synchronous active-high reset
//   bus      : request/grant/broadcast bundle (master side)
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.master bus
);

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0] wait_q [N_REQ];
    logic [WAIT_W-1:0] wait_d [N_REQ];
    logic [N_REQ-1:0]  starve_q, starve_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    logic [N_REQ-1:0]  rr_grant;
    logic [IDX_W-1:0]  rr_idx;
    logic              rr_valid;
    logic [N_REQ-1:0]  starved_req;
    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  win_idx;
    logic              arb_en;

    rr_arbiter #(.N(N_REQ), .W(IDX_W)) u_rr (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    assign starved_req = bus.req & starve_q;
    assign arb_en      = !rst && !bus.cdb_stall && !bus.flush && rr_valid;

    // Starved requesters override the round-robin choice; scanning downward
    // leaves the lowest starved index as the winner.
    always_comb begin
        win_idx = rr_idx;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (starved_req[i]) win_idx = IDX_W'(i);
        end
        grant = '0;
        if (arb_en) grant[win_idx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        if (|grant) begin
            rr_ptr_d    = next_ptr(win_idx);
            cdb_valid_d = 1'b1;
            cdb_tag_d   = bus.req_tag[win_idx*TAG_W +: TAG_W];
            cdb_data_d  = bus.req_data[win_idx*DATA_W +: DATA_W];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.flush || !bus.req[i] || grant[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_SAT) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end else begin
                wait_d[i] = wait_q[i];
            end
            starve_d[i] = (int'(wait_d[i]) >= MAX_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            starve_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            starve_q    <= starve_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign bus.grant     = grant;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.starve    = starve_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_pkg::*;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } sb_item_t;

    logic clk;
    logic rst;
    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    sb_item_t sb[$];
    logic [TAG_W-1:0]  tags  [N_REQ];
    logic [DATA_W-1:0] datas [N_REQ];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // One clock cycle: mid-cycle compare of grant and of the broadcast owed by
    // the previous cycle, record what this cycle's grant must broadcast, then
    // advance to just after the next rising edge.
    task automatic cycle(input string nm, input logic [N_REQ-1:0] exp_g, input bit drop);
        sb_item_t it;
        #3;
        check({nm, ".grant"}, 64'(bus.grant), 64'(exp_g));
        if (sb.size() != 0) begin
            it = sb.pop_front();
            check({nm, ".cdb_valid"}, 64'(bus.cdb_valid), 64'(1));
            check({nm, ".cdb_tag"},   64'(bus.cdb_tag),   64'(it.tag));
            check({nm, ".cdb_data"},  64'(bus.cdb_data),  64'(it.data));
        end else begin
            check({nm, ".cdb_valid"}, 64'(bus.cdb_valid), 64'(0));
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_g[i]) begin
                it.tag  = tags[i];
                it.data = datas[i];
                sb.push_back(it);
            end
        end
        @(posedge clk);
        #1;
        if (drop) bus.req = bus.req & ~exp_g;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        check("rst.grant", 64'(bus.grant), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.cdb_stall = 1'b0;
        bus.flush     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            tags[i]  = TAG_W'((i + 3) % 8);
            datas[i] = 32'hA5A5_0000 + 32'(i * 32'h111);
        end
        datas[0] = 32'hDEAD_BEEF;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_tag[i*TAG_W +: TAG_W]    = tags[i];
            bus.req_data[i*DATA_W +: DATA_W] = datas[i];
        end
        @(posedge clk);
        #1;

        // reset state, with every requester asking
        bus.req = '1;
        do_reset();
        bus.req = '0;
        #3;
        check("reset.cdb_valid", 64'(bus.cdb_valid), 64'(0));
        check("reset.cdb_tag",   64'(bus.cdb_tag),   64'(0));
        check("reset.cdb_data",  64'(bus.cdb_data),  64'(0));
        check("reset.starve",    64'(bus.starve),    64'(0));
        @(posedge clk);
        #1;

        // 1: single request, one-cycle latency
        bus.req = 6'b000001;
        cycle("t1", 6'b000001, 1'b1);
        cycle("t1", 6'b000000, 1'b1);

        // 2: all request from rr_ptr=0, each drops after its grant
        do_reset();
        bus.req = 6'b111111;
        for (int k = 0; k < N_REQ; k++) cycle("t2", 6'(1 << k), 1'b1);
        cycle("t2", 6'b000000, 1'b1);

        // 3: rr_ptr driven to 5, then wrap 5 -> 0, pointer ends at 1
        bus.req = 6'b010000;
        cycle("t3", 6'b010000, 1'b1);
        bus.req = 6'b100001;
        cycle("t3", 6'b100000, 1'b1);
        cycle("t3", 6'b000001, 1'b1);
        bus.req = 6'b000011;
        cycle("t3", 6'b000010, 1'b1);
        cycle("t3", 6'b000001, 1'b1);

        // sole requester held: granted every cycle, no gaps
        bus.req = 6'b000100;
        for (int k = 0; k < 3; k++) cycle("sole", 6'b000100, 1'b0);
        bus.req = '0;
        cycle("sole", 6'b000000, 1'b1);

        // 4: stall with req[3], then grant 3 once stall drops
        bus.req       = 6'b001000;
        bus.cdb_stall = 1'b1;
        for (int k = 0; k < 3; k++) cycle("t4", 6'b000000, 1'b0);
        bus.cdb_stall = 1'b0;
        check("t4.starve", 64'(bus.starve), 64'(0));
        cycle("t4", 6'b001000, 1'b1);

        // 5: grant idx2 (rr_ptr=4), flush next cycle
        bus.req = 6'b000100;
        cycle("t5", 6'b000100, 1'b1);
        bus.req   = 6'b000010;
        bus.flush = 1'b1;
        cycle("t5", 6'b000000, 1'b0);
        bus.flush = 1'b0;
        check("t5.starve", 64'(bus.starve), 64'(0));
        cycle("t5", 6'b000010, 1'b1);
        cycle("t5", 6'b000000, 1'b1);

        // 6: req[4] starves under a 15-cycle stall, then wins by override
        do_reset();
        bus.req       = 6'b010000;
        bus.cdb_stall = 1'b1;
        for (int k = 0; k < MAX_WAIT; k++) begin
            #2;
            check("t6.starve_pre", 64'(bus.starve[4]), 64'(0));
            #1;
            cycle("t6", 6'b000000, 1'b0);
            #0;
            bus.req = 6'b010000;
        end
        bus.cdb_stall = 1'b0;
        bus.req       = 6'b011111;
        #2;
        check("t6.starve", 64'(bus.starve), 64'(6'b010000));
        #1;
        cycle("t6", 6'b010000, 1'b1);
        #2;
        check("t6.starve_clr", 64'(bus.starve), 64'(0));
        #1;
        cycle("t6", 6'b000001, 1'b1);
        bus.req = '0;
        cycle("t6", 6'b000000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
